// File: rtl/core_if_id.sv
`default_nettype none
// ============================================================================
// Module   : core_if_id
// Function : fetch-to-decode pipeline register with hold handling, post-jump
//            squash window, slot valid tagging and a saturating bubble counter.
// Revision : 1.0
// ============================================================================
module core_if_id #(
    parameter int FLUSH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_in,
    input  logic [31:0] inst_addr_in,
    input  logic [2:0]  hold_flag_in,
    input  logic        jump_flag_in,
    output logic [31:0] inst_out,
    output logic [31:0] inst_addr_out,
    output logic        inst_valid_out,
    output logic [31:0] bubble_cnt_out
);

    localparam logic [31:0] C_INST_NOP  = 32'h0000_0013;
    localparam logic [2:0]  C_HOLD_PC   = 3'd1;
    localparam logic [2:0]  C_HOLD_IF   = 3'd2;
    localparam logic [2:0]  C_KILL_INIT = 3'(FLUSH_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_KILL = 1'b1
    } state_t;

    logic [31:0] inst_q, inst_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [2:0]  kill_cnt_q, kill_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic        w_bubble;
    state_t      w_state;

    // The squash window is fully described by the remaining kill count.
    assign w_state = (kill_cnt_q != 3'd0) ? ST_KILL : ST_RUN;

    always_comb begin
        inst_d     = inst_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        kill_cnt_d = kill_cnt_q;
        w_bubble   = 1'b0;
        if (jump_flag_in) begin
            inst_d     = C_INST_NOP;
            addr_d     = inst_addr_in;
            valid_d    = 1'b0;
            kill_cnt_d = C_KILL_INIT;
            w_bubble   = 1'b1;
        end else if (hold_flag_in >= C_HOLD_IF) begin
            inst_d = inst_q;
        end else if (w_state == ST_KILL) begin
            inst_d     = C_INST_NOP;
            addr_d     = inst_addr_in;
            valid_d    = 1'b0;
            kill_cnt_d = kill_cnt_q - 3'd1;
            w_bubble   = 1'b1;
        end else if (hold_flag_in == C_HOLD_PC) begin
            inst_d   = inst_in;
            addr_d   = inst_addr_in;
            valid_d  = 1'b0;
            w_bubble = 1'b1;
        end else begin
            inst_d  = inst_in;
            addr_d  = inst_addr_in;
            valid_d = 1'b1;
        end
    end

    assign bubble_cnt_d = (w_bubble && (bubble_cnt_q != 32'hFFFF_FFFF))
                        ? bubble_cnt_q + 32'd1 : bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q       <= C_INST_NOP;
            addr_q       <= 32'd0;
            valid_q      <= 1'b0;
            kill_cnt_q   <= 3'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            inst_q       <= inst_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            kill_cnt_q   <= kill_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign inst_out       = inst_q;
    assign inst_addr_out  = addr_q;
    assign inst_valid_out = valid_q;
    assign bubble_cnt_out = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_core_if_id.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_if_id
// Function : scoreboard bench for core_if_id (FLUSH_DEPTH 2 and 3 instances).
// Revision : 1.0
// ============================================================================
module tb_core_if_id;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] inst_in;
    logic [31:0] inst_addr_in;
    logic [2:0]  hold_flag_in;
    logic        jump_flag_in;

    logic [31:0] a_inst, a_addr, a_bc;
    logic        a_v;
    logic [31:0] b_inst, b_addr, b_bc;
    logic        b_v;

    core_if_id #(.FLUSH_DEPTH(2)) dut_a (
        .clk(clk), .rst(rst), .inst_in(inst_in), .inst_addr_in(inst_addr_in),
        .hold_flag_in(hold_flag_in), .jump_flag_in(jump_flag_in),
        .inst_out(a_inst), .inst_addr_out(a_addr),
        .inst_valid_out(a_v), .bubble_cnt_out(a_bc)
    );

    core_if_id #(.FLUSH_DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .inst_in(inst_in), .inst_addr_in(inst_addr_in),
        .hold_flag_in(hold_flag_in), .jump_flag_in(jump_flag_in),
        .inst_out(b_inst), .inst_addr_out(b_addr),
        .inst_valid_out(b_v), .bubble_cnt_out(b_bc)
    );

    typedef struct {
        int          id;
        bit          sel_b;
        logic [31:0] inst;
        logic [31:0] addr;
        logic        v;
        logic [31:0] bc;
    } exp_t;

    exp_t q[$];
    int   edges = 0;
    int   total = 0;
    int   bad   = 0;
    int   cur   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: each edge, pop every entry due for it and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            edges = edges + 1;
            while (q.size() > 0 && q[0].id <= edges) begin
                e = q.pop_front();
                total = total + 1;
                if (e.id < edges) begin
                    bad = bad + 1;
                    $display("FAIL stale_entry id=%0d edge=%0d", e.id, edges);
                end else if (!e.sel_b && (a_inst !== e.inst || a_addr !== e.addr
                             || a_v !== e.v || a_bc !== e.bc)) begin
                    bad = bad + 1;
                    $display("FAIL fd2_slot edge=%0d got inst=%h addr=%h v=%b bc=%h want inst=%h addr=%h v=%b bc=%h",
                             edges, a_inst, a_addr, a_v, a_bc, e.inst, e.addr, e.v, e.bc);
                end else if (e.sel_b && (b_inst !== e.inst || b_addr !== e.addr
                             || b_v !== e.v || b_bc !== e.bc)) begin
                    bad = bad + 1;
                    $display("FAIL fd3_slot edge=%0d got inst=%h addr=%h v=%b bc=%h want inst=%h addr=%h v=%b bc=%h",
                             edges, b_inst, b_addr, b_v, b_bc, e.inst, e.addr, e.v, e.bc);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic [2:0] h, input logic j,
                         input logic [31:0] ins, input logic [31:0] adr);
        @(negedge clk);
        rst          = r;
        hold_flag_in = h;
        jump_flag_in = j;
        inst_in      = ins;
        inst_addr_in = adr;
        cur          = edges + 1;
    endtask

    task automatic expect_slot(input bit sb, input logic [31:0] ins,
                               input logic [31:0] adr, input logic v,
                               input logic [31:0] bc);
        exp_t e;
        e.id = cur; e.sel_b = sb; e.inst = ins; e.addr = adr; e.v = v; e.bc = bc;
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; hold_flag_in = 3'd0; jump_flag_in = 1'b0;
        inst_in = C_NOP; inst_addr_in = 32'd0;

        // Reset for two edges, then first normal load.
        drive(1, 0, 0, 32'h0040_0093, 32'h100); expect_slot(0, C_NOP, 0, 0, 0);
        drive(1, 0, 0, 32'h0040_0093, 32'h100); expect_slot(0, C_NOP, 0, 0, 0);
        expect_slot(1, C_NOP, 0, 0, 0);
        drive(0, 0, 0, 32'h0040_0093, 32'h100); expect_slot(0, 32'h0040_0093, 32'h100, 1, 0);

        // Streaming
        drive(0, 0, 0, 32'h00a0_0093, 32'h0); expect_slot(0, 32'h00a0_0093, 32'h0, 1, 0);
        drive(0, 0, 0, 32'h00b0_0113, 32'h4); expect_slot(0, 32'h00b0_0113, 32'h4, 1, 0);
        drive(0, 0, 0, 32'h00c0_0193, 32'h8); expect_slot(0, 32'h00c0_0193, 32'h8, 1, 0);

        // Jump squash with FLUSH_DEPTH 2
        drive(0, 0, 1, 32'h1110_0093, 32'hC);  expect_slot(0, C_NOP, 32'hC, 0, 1);
        drive(0, 0, 0, 32'h2220_0093, 32'h40); expect_slot(0, C_NOP, 32'h40, 0, 2);
        drive(0, 0, 0, 32'h3330_0093, 32'h44); expect_slot(0, 32'h3330_0093, 32'h44, 1, 2);

        // HoldId freezes, HoldPc inserts a counted bubble
        for (int i = 0; i < 3; i++) begin
            drive(0, 3, 0, 32'hDEAD_0000 + 32'(i), 32'h900 + 32'(i));
            expect_slot(0, 32'h3330_0093, 32'h44, 1, 2);
        end
        drive(0, 1, 0, C_NOP, 32'h48);         expect_slot(0, C_NOP, 32'h48, 0, 3);
        drive(0, 0, 0, 32'h00d0_0213, 32'h48); expect_slot(0, 32'h00d0_0213, 32'h48, 1, 3);

        // Jump under HoldIf, then HoldIf freezes the kill window
        drive(0, 2, 1, 32'hBAD0_0001, 32'h80); expect_slot(0, C_NOP, 32'h80, 0, 4);
        drive(0, 2, 0, 32'hBAD0_0002, 32'h84); expect_slot(0, C_NOP, 32'h80, 0, 4);
        drive(0, 0, 0, 32'hBAD0_0003, 32'h84); expect_slot(0, C_NOP, 32'h84, 0, 5);
        drive(0, 0, 0, 32'h00e0_0293, 32'h88); expect_slot(0, 32'h00e0_0293, 32'h88, 1, 5);

        // Re-jump: reset both, then jumps on two consecutive edges
        drive(1, 0, 0, 32'hBAD0_0004, 32'h1FC);
        expect_slot(0, C_NOP, 0, 0, 0); expect_slot(1, C_NOP, 0, 0, 0);
        drive(0, 0, 0, 32'h0010_0313, 32'h200);
        expect_slot(0, 32'h0010_0313, 32'h200, 1, 0); expect_slot(1, 32'h0010_0313, 32'h200, 1, 0);
        drive(0, 0, 1, 32'hBAD0_0005, 32'h300);
        expect_slot(0, C_NOP, 32'h300, 0, 1); expect_slot(1, C_NOP, 32'h300, 0, 1);
        drive(0, 0, 1, 32'hBAD0_0006, 32'h304);
        expect_slot(0, C_NOP, 32'h304, 0, 2); expect_slot(1, C_NOP, 32'h304, 0, 2);
        drive(0, 0, 0, 32'h0020_0393, 32'h308);
        expect_slot(0, C_NOP, 32'h308, 0, 3); expect_slot(1, C_NOP, 32'h308, 0, 3);
        drive(0, 0, 0, 32'h0030_0413, 32'h30C);
        expect_slot(0, 32'h0030_0413, 32'h30C, 1, 3); expect_slot(1, C_NOP, 32'h30C, 0, 4);
        drive(0, 0, 0, 32'h0040_0493, 32'h310);
        expect_slot(0, 32'h0040_0493, 32'h310, 1, 3); expect_slot(1, 32'h0040_0493, 32'h310, 1, 4);

        // Saturation: preload the counter across a frozen edge, then 3 bubbles
        @(negedge clk);
        force dut_a.bubble_cnt_q = 32'hFFFF_FFFE;
        drive(0, 3, 0, 32'hBAD0_0007, 32'h3F0);
        expect_slot(0, 32'h0040_0493, 32'h310, 1, 32'hFFFF_FFFE);
        @(negedge clk);
        release dut_a.bubble_cnt_q;
        drive(0, 0, 1, 32'hBAD0_0008, 32'h400); expect_slot(0, C_NOP, 32'h400, 0, 32'hFFFF_FFFF);
        drive(0, 0, 0, 32'hBAD0_0009, 32'h404); expect_slot(0, C_NOP, 32'h404, 0, 32'hFFFF_FFFF);
        drive(0, 1, 0, C_NOP, 32'h408);         expect_slot(0, C_NOP, 32'h408, 0, 32'hFFFF_FFFF);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain_timeout left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
